// File: rtl/onehot_pulse_decoder_if.sv
// rtl/onehot_pulse_decoder_if.sv - request handshake for the one-hot pulse decoder
// Ports (signals):
//   in_valid  request valid            (master -> slave)
//   in_ready  request slot free        (slave  -> master)
//   in_index  line to pulse, n bits    (master -> slave)
//   in_hold   pulse length, hw bits    (master -> slave)
interface onehot_pulse_decoder_if #(
    parameter int n  = 2,
    parameter int hw = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [n-1:0]  in_index;
    logic [hw-1:0] in_hold;

    modport master (output in_valid, in_index, in_hold, input in_ready);
    modport slave  (input in_valid, in_index, in_hold, output in_ready);
endinterface

// File: rtl/onehot_pulse_decoder.sv
// rtl/onehot_pulse_decoder.sv - registered one-hot pulse generator with pending slot
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   s_req  request handshake (slave): in_valid/in_ready/in_index/in_hold
//   out    registered one-hot pulse, all-zero when idle
//   done   one-cycle pulse on the edge a pulse ends
//   err    one-cycle pulse when a request names a line >= m
//   busy   state machine active or a request pending
module onehot_pulse_decoder #(
    parameter int m   = 4,
    parameter int n   = 2,
    parameter int hw  = 4,
    parameter int gap = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    onehot_pulse_decoder_if.slave        s_req,
    output logic [m-1:0]                 out,
    output logic                         done,
    output logic                         err,
    output logic                         busy
);
    localparam int GW = (gap > 1) ? $clog2(gap + 1) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

    state_t        r_state, w_nxt_state;
    logic [m-1:0]  r_out, w_nxt_out;
    logic          r_done, w_nxt_done;
    logic          r_err, w_nxt_err;
    logic          r_pend_valid, w_nxt_pend_valid;
    logic [n-1:0]  r_pend_index;
    logic [hw-1:0] r_pend_hold;
    logic [hw-1:0] r_hcnt, w_nxt_hcnt;
    logic [GW-1:0] r_gcnt, w_nxt_gcnt;

    logic          w_accept;
    logic          w_try_load;
    logic          w_pend_ok;
    logic [m-1:0]  w_onehot;
    logic [hw-1:0] w_len;

    assign s_req.in_ready = !r_pend_valid;
    assign w_accept       = s_req.in_valid && !r_pend_valid;

    assign w_pend_ok = ({{(32-n){1'b0}}, r_pend_index} < 32'(m));
    assign w_onehot  = {{(m-1){1'b0}}, 1'b1} << r_pend_index;
    // A hold of zero still produces a single-cycle pulse.
    assign w_len     = (r_pend_hold == '0) ? hw'(1) : r_pend_hold;

    assign out  = r_out;
    assign done = r_done;
    assign err  = r_err;
    assign busy = (r_state != IDLE) || r_pend_valid;

    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_out        = r_out;
        w_nxt_done       = 1'b0;
        w_nxt_err        = 1'b0;
        w_nxt_pend_valid = r_pend_valid;
        w_nxt_hcnt       = r_hcnt;
        w_nxt_gcnt       = r_gcnt;
        w_try_load       = 1'b0;

        // Accept and load never coincide: accept needs an empty slot,
        // load needs a full one.
        if (w_accept) begin
            w_nxt_pend_valid = 1'b1;
        end

        case (r_state)
            IDLE: begin
                w_try_load = 1'b1;
            end
            DRIVE: begin
                w_nxt_hcnt = r_hcnt - hw'(1);
                if (r_hcnt == hw'(1)) begin
                    w_nxt_done  = 1'b1;
                    w_nxt_out   = '0;
                    if (gap > 0) begin
                        w_nxt_gcnt  = GW'(gap);
                        w_nxt_state = GAP;
                    end else begin
                        // No gap: a pending request takes over on this edge,
                        // switching one-hot to one-hot with no zero cycle.
                        w_nxt_state = IDLE;
                        w_try_load  = 1'b1;
                    end
                end
            end
            GAP: begin
                w_nxt_gcnt = r_gcnt - GW'(1);
                if (r_gcnt == GW'(1)) begin
                    // Load in the same edge so the gap is exactly gap cycles.
                    w_nxt_state = IDLE;
                    w_try_load  = 1'b1;
                end
            end
            default: begin
                w_nxt_state = IDLE;
                w_nxt_out   = '0;
            end
        endcase

        if (w_try_load && r_pend_valid) begin
            w_nxt_pend_valid = 1'b0;
            if (w_pend_ok) begin
                w_nxt_out   = w_onehot;
                w_nxt_hcnt  = w_len;
                w_nxt_state = DRIVE;
            end else begin
                w_nxt_err   = 1'b1;
                w_nxt_out   = '0;
                w_nxt_state = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_out        <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_index <= '0;
            r_pend_hold  <= '0;
            r_hcnt       <= '0;
            r_gcnt       <= '0;
        end else begin
            r_state      <= w_nxt_state;
            r_out        <= w_nxt_out;
            r_done       <= w_nxt_done;
            r_err        <= w_nxt_err;
            r_pend_valid <= w_nxt_pend_valid;
            r_hcnt       <= w_nxt_hcnt;
            r_gcnt       <= w_nxt_gcnt;
            if (w_accept) begin
                r_pend_index <= s_req.in_index;
                r_pend_hold  <= s_req.in_hold;
            end
        end
    end
endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// tb/tb_onehot_pulse_decoder.sv - directed self-checking bench for onehot_pulse_decoder
module tb_onehot_pulse_decoder;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    onehot_pulse_decoder_if #(.n(2), .hw(4)) if_a ();
    onehot_pulse_decoder_if #(.n(2), .hw(4)) if_b ();
    onehot_pulse_decoder_if #(.n(3), .hw(4)) if_c ();

    logic [3:0] out_a, out_b;
    logic [4:0] out_c;
    logic done_a, err_a, busy_a;
    logic done_b, err_b, busy_b;
    logic done_c, err_c, busy_c;

    onehot_pulse_decoder #(.m(4), .n(2), .hw(4), .gap(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .s_req(if_a),
        .out(out_a), .done(done_a), .err(err_a), .busy(busy_a)
    );
    onehot_pulse_decoder #(.m(4), .n(2), .hw(4), .gap(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_req(if_b),
        .out(out_b), .done(done_b), .err(err_b), .busy(busy_b)
    );
    onehot_pulse_decoder #(.m(5), .n(3), .hw(4), .gap(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .s_req(if_c),
        .out(out_c), .done(done_c), .err(err_c), .busy(busy_c)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic v, input logic [1:0] idx, input logic [3:0] hold);
        if_a.in_valid = v; if_a.in_index = idx; if_a.in_hold = hold;
    endtask
    task automatic set_b(input logic v, input logic [1:0] idx, input logic [3:0] hold);
        if_b.in_valid = v; if_b.in_index = idx; if_b.in_hold = hold;
    endtask
    task automatic set_c(input logic v, input logic [2:0] idx, input logic [3:0] hold);
        if_c.in_valid = v; if_c.in_index = idx; if_c.in_hold = hold;
    endtask

    initial begin
        rst_n = 1'b0;
        set_a(1'b0, 2'd0, 4'd0);
        set_b(1'b0, 2'd0, 4'd0);
        set_c(1'b0, 3'd0, 4'd0);

        // 1: reset state and quiet idle
        #1;
        chk("rst_out_a",   32'(out_a), 32'h0);
        chk("rst_ready_a", 32'(if_a.in_ready), 32'h1);
        chk("rst_busy_a",  32'(busy_a), 32'h0);
        chk("rst_done_a",  32'(done_a), 32'h0);
        chk("rst_err_a",   32'(err_a), 32'h0);
        chk("rst_out_c",   32'(out_c), 32'h0);
        #11 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_out_a",  32'(out_a), 32'h0);
            chk("idle_busy_a", 32'(busy_a), 32'h0);
        end

        // 2: index 2, hold 3, gap 1
        set_a(1'b1, 2'd2, 4'd3); step(); set_a(1'b0, 2'd0, 4'd0);
        chk("t2_ready_e0", 32'(if_a.in_ready), 32'h0);
        step(); chk("t2_out_e1", 32'(out_a), 32'h4);
        step(); chk("t2_out_e2", 32'(out_a), 32'h4);
        step(); chk("t2_out_e3", 32'(out_a), 32'h4);
        chk("t2_done_e3", 32'(done_a), 32'h0);
        step(); chk("t2_out_e4", 32'(out_a), 32'h0);
        chk("t2_done_e4", 32'(done_a), 32'h1);
        chk("t2_busy_e4", 32'(busy_a), 32'h1);
        step(); chk("t2_busy_e5", 32'(busy_a), 32'h0);
        chk("t2_done_e5", 32'(done_a), 32'h0);

        // 3: hold 0 acts as 1
        set_a(1'b1, 2'd1, 4'd0); step(); set_a(1'b0, 2'd0, 4'd0);
        step(); chk("t3_out_e1", 32'(out_a), 32'h2);
        chk("t3_done_e1", 32'(done_a), 32'h0);
        step(); chk("t3_out_e2", 32'(out_a), 32'h0);
        chk("t3_done_e2", 32'(done_a), 32'h1);
        step(); chk("t3_busy_e3", 32'(busy_a), 32'h0);

        // 4a: back-to-back with gap 1
        set_a(1'b1, 2'd0, 4'd2); step(); set_a(1'b0, 2'd0, 4'd0);
        step(); chk("t4a_out_e1", 32'(out_a), 32'h1);
        chk("t4a_ready_e1", 32'(if_a.in_ready), 32'h1);
        set_a(1'b1, 2'd3, 4'd1); step(); set_a(1'b0, 2'd0, 4'd0);
        chk("t4a_out_e2", 32'(out_a), 32'h1);
        step(); chk("t4a_out_e3", 32'(out_a), 32'h0);
        chk("t4a_done_e3", 32'(done_a), 32'h1);
        step(); chk("t4a_out_e4", 32'(out_a), 32'h8);
        chk("t4a_done_e4", 32'(done_a), 32'h0);
        step(); chk("t4a_out_e5", 32'(out_a), 32'h0);
        chk("t4a_done_e5", 32'(done_a), 32'h1);
        step(); chk("t4a_busy_e6", 32'(busy_a), 32'h0);

        // 4b: back-to-back with gap 0
        set_b(1'b1, 2'd0, 4'd2); step(); set_b(1'b0, 2'd0, 4'd0);
        step(); chk("t4b_out_e1", 32'(out_b), 32'h1);
        set_b(1'b1, 2'd3, 4'd1); step(); set_b(1'b0, 2'd0, 4'd0);
        chk("t4b_out_e2", 32'(out_b), 32'h1);
        step(); chk("t4b_out_e3", 32'(out_b), 32'h8);
        chk("t4b_done_e3", 32'(done_b), 32'h1);
        step(); chk("t4b_out_e4", 32'(out_b), 32'h0);
        chk("t4b_done_e4", 32'(done_b), 32'h1);
        chk("t4b_busy_e4", 32'(busy_b), 32'h0);

        // 5: out-of-range index on m=5
        set_c(1'b1, 3'd6, 4'd2); step(); set_c(1'b0, 3'd0, 4'd0);
        chk("t5_ready_e0", 32'(if_c.in_ready), 32'h0);
        step(); chk("t5_err_e1", 32'(err_c), 32'h1);
        chk("t5_out_e1",   32'(out_c), 32'h0);
        chk("t5_done_e1",  32'(done_c), 32'h0);
        chk("t5_ready_e1", 32'(if_c.in_ready), 32'h1);
        step(); chk("t5_err_e2", 32'(err_c), 32'h0);
        chk("t5_out_e2", 32'(out_c), 32'h0);
        set_c(1'b1, 3'd4, 4'd1); step(); set_c(1'b0, 3'd0, 4'd0);
        step(); chk("t5_out4_e1", 32'(out_c), 32'h10);
        chk("t5_err4_e1", 32'(err_c), 32'h0);
        step(); chk("t5_out4_e2", 32'(out_c), 32'h0);
        chk("t5_done4_e2", 32'(done_c), 32'h1);

        // 6: async reset mid-pulse with a request pending
        set_a(1'b1, 2'd2, 4'd5); step(); set_a(1'b0, 2'd0, 4'd0);
        step(); chk("t6_out_e1", 32'(out_a), 32'h4);
        set_a(1'b1, 2'd1, 4'd3); step(); set_a(1'b0, 2'd0, 4'd0);
        chk("t6_pend_ready", 32'(if_a.in_ready), 32'h0);
        chk("t6_out_e2", 32'(out_a), 32'h4);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_out",   32'(out_a), 32'h0);
        chk("t6_rst_ready", 32'(if_a.in_ready), 32'h1);
        chk("t6_rst_busy",  32'(busy_a), 32'h0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t6_post_out",  32'(out_a), 32'h0);
            chk("t6_post_busy", 32'(busy_a), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
